// File: rtl/trace_pkg.sv
// Shared types and constants for the fetch-trace monitor.
// Contents: run-state encodings, trace entry payload, width helpers.
package trace_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CYCLE_W = 32;

    // Run-controller states (plain constants so legacy tools can consume them)
    typedef logic [1:0] state_t;
    localparam state_t ST_HOLD = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // One trace record at the default PC width; the buffer stores {pc, instr}
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } trace_entry_t;

    // Bits needed to hold values 0..n inclusive
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Ring buffer with overwrite-on-full, registered head output and sticky overflow.
// Ports: clk, reset (sync, active-high), wr/wdata (push), rd_ready (pop request),
//        rd_valid/rd_data (registered head), count (occupancy), overflow (sticky).
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [W-1:0]             wdata,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_next;
    logic [CNT_W-1:0] count_next;
    logic [W-1:0]     head_data_next;
    logic             full;
    logic             empty;
    logic             pop;
    logic             ovw;

    // Pointer/occupancy update; head data is forwarded from the write when they collide
    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        empty      = (count == '0);
        pop        = rd_ready && !empty;
        ovw        = wr && full && !pop;
        head_next  = head + PTR_W'(pop || ovw);
        count_next = count;
        if (wr && !pop && !full) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !wr) begin
            count_next = count - CNT_W'(1);
        end
        head_data_next = (wr && (tail == head_next)) ? wdata : mem[head_next];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr) begin
                mem[tail] <= wdata;
                tail      <= tail + PTR_W'(1);
            end
            if (ovw) begin
                overflow <= 1'b1;
            end
            head     <= head_next;
            count    <= count_next;
            rd_valid <= (count_next != '0);
            rd_data  <= head_data_next;
        end
    end

endmodule

// File: rtl/pc_trace_monitor.sv
// Run controller and fetch-trace buffer for the rv32im core.
// Sequences core reset (HOLD), captures {pc, instr} while running (RUN), and stops
// on halt (repeated PC) or timeout (DONE). Optional TRACE_DEDUP_EN drops captures
// whose PC equals the previous captured PC from the buffer.
// Ports: clk, reset (sync, active-high), core_reset, cap_en, pc_in, instr_in,
//        rd_ready/rd_valid/rd_pc/rd_instr (drain), count, overflow, halted,
//        timeout, cycle_cnt.
module pc_trace_monitor
    import trace_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned RST_HOLD    = 2,
    parameter int unsigned TIMEOUT     = 100,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   core_reset,
    input  logic                   cap_en,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [INSTR_W-1:0]     instr_in,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [XLEN-1:0]        rd_pc,
    output logic [INSTR_W-1:0]     rd_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   halted,
    output logic                   timeout,
    output logic [CYCLE_W-1:0]     cycle_cnt
);

    localparam int unsigned HOLD_W  = cnt_width(RST_HOLD);
    localparam int unsigned REP_W   = cnt_width(HALT_REPEAT);
    localparam int unsigned ENTRY_W = XLEN + INSTR_W;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_next;
    logic [XLEN-1:0]   prev_pc;
    logic              prev_valid;
    logic              capture;
    logic              same_pc;
    logic              wr;
    logic              halt_hit;
    logic              timeout_hit;
    logic [ENTRY_W-1:0] rd_data;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Next state, capture qualification and halt/timeout detection
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        same_pc     = 1'b0;
        rep_next    = rep_cnt;
        halt_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                capture = cap_en;
                // prev_valid keeps the very first capture from matching the reset PC
                same_pc = prev_valid && (pc_in == prev_pc);
                if (capture) begin
                    rep_next = same_pc ? (rep_cnt + REP_W'(1)) : REP_W'(1);
                end
                halt_hit    = capture && (rep_next == REP_W'(HALT_REPEAT));
                timeout_hit = (cycle_cnt == CYCLE_W'(TIMEOUT - 1));
                if (halt_hit || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
            end
        endcase
`ifdef TRACE_DEDUP_EN
        wr = capture && !same_pc;
`else
        wr = capture;
`endif
    end

    // Reset sequencing, run counters and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset <= 1'b1;
            hold_cnt   <= '0;
            cycle_cnt  <= '0;
            rep_cnt    <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            // Registered from the current state, so core_reset drops one cycle after RUN is entered
            core_reset <= (state == ST_HOLD);
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if ((state == ST_RUN) && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + CYCLE_W'(1);
            end
            if (capture) begin
                rep_cnt    <= rep_next;
                prev_pc    <= pc_in;
                prev_valid <= 1'b1;
            end
            if (halt_hit) begin
                halted <= 1'b1;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .wdata    ({pc_in, instr_in}),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    assign rd_pc    = rd_data[ENTRY_W-1:INSTR_W];
    assign rd_instr = rd_data[INSTR_W-1:0];

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor at default parameters
// (XLEN=32, DEPTH=16, RST_HOLD=2, TIMEOUT=100, HALT_REPEAT=4).
module tb_pc_trace_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_reset;
    logic        cap_en;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [4:0]  count;
    logic        overflow;
    logic        halted;
    logic        timeout;
    logic [31:0] cycle_cnt;

    int errors = 0;
    int checks = 0;

    pc_trace_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .core_reset (core_reset),
        .cap_en     (cap_en),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_pc      (rd_pc),
        .rd_instr   (rd_instr),
        .count      (count),
        .overflow   (overflow),
        .halted     (halted),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before driving/sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    task automatic cap(input logic [31:0] pc);
        cap_en   = 1'b1;
        pc_in    = pc;
        instr_in = ins(pc);
        tick();
        cap_en   = 1'b0;
    endtask

    // Reset for one cycle, then wait through HOLD: afterwards state is RUN, cycle_cnt=0
    task automatic start();
        reset    = 1'b1;
        cap_en   = 1'b0;
        rd_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        cap_en   = 1'b0;
        rd_ready = 1'b0;
        pc_in    = '0;
        instr_in = '0;

        // Reset sequencing: 3 reset cycles, then core_reset high for 2 more
        tick(); tick(); tick();
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_count",      64'(count),      64'd0);
        chk("rst_rd_valid",   64'(rd_valid),   64'd0);
        chk("rst_cycle_cnt",  64'(cycle_cnt),  64'd0);
        chk("rst_flags",      64'({overflow, halted, timeout}), 64'd0);
        reset = 1'b0;
        tick();
        chk("hold_1_core_reset", 64'(core_reset), 64'd1);
        tick();
        chk("hold_2_core_reset", 64'(core_reset), 64'd1);
        chk("hold_2_cycle_cnt",  64'(cycle_cnt),  64'd0);
        tick();
        chk("run_core_reset", 64'(core_reset), 64'd0);
        chk("run_cycle_cnt",  64'(cycle_cnt),  64'd1);
        chk("run_count",      64'(count),      64'd0);

        // Linear capture and in-order drain
        start();
        for (int i = 0; i < 8; i++) cap(32'(4 * i));
        chk("lin_count",    64'(count),    64'd8);
        chk("lin_rd_valid", 64'(rd_valid), 64'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("lin_rd_pc",    64'(rd_pc),    64'(4 * i));
            chk("lin_rd_instr", 64'(rd_instr), 64'(ins(32'(4 * i))));
            tick();
        end
        rd_ready = 1'b0;
        chk("lin_drained_count", 64'(count),    64'd0);
        chk("lin_drained_valid", 64'(rd_valid), 64'd0);

        // Empty buffer with simultaneous write and pop: entry survives
        start();
        rd_ready = 1'b1;
        cap(32'h40);
        chk("ewp_count",    64'(count),    64'd1);
        chk("ewp_rd_valid", 64'(rd_valid), 64'd1);
        chk("ewp_rd_pc",    64'(rd_pc),    64'h40);
        tick();
        rd_ready = 1'b0;
        chk("ewp_pop_count", 64'(count), 64'd0);

        // Overflow: 20 captures into 16 entries
        start();
        for (int i = 0; i < 20; i++) cap(32'(4 * i));
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_count", 64'(count),    64'd16);
        rd_ready = 1'b1;
        for (int i = 4; i < 20; i++) begin
            chk("ovf_rd_pc", 64'(rd_pc), 64'(4 * i));
            tick();
        end
        rd_ready = 1'b0;
        chk("ovf_drained_count", 64'(count), 64'd0);

        // Full with simultaneous pop and write: no overwrite
        start();
        for (int i = 0; i < 16; i++) cap(32'h100 + 32'(4 * i));
        chk("fpw_pre_count",    64'(count),    64'd16);
        chk("fpw_pre_overflow", 64'(overflow), 64'd0);
        rd_ready = 1'b1;
        cap(32'h200);
        rd_ready = 1'b0;
        chk("fpw_count",    64'(count),    64'd16);
        chk("fpw_overflow", 64'(overflow), 64'd0);
        chk("fpw_rd_pc",    64'(rd_pc),    64'h104);
        cap(32'h204);
        chk("fpw_ovw_overflow", 64'(overflow), 64'd1);
        chk("fpw_ovw_rd_pc",    64'(rd_pc),    64'h108);

        // Halt: 0x10 once, then 0x20 four times
        start();
        cap(32'h10);
        cap(32'h20); cap(32'h20); cap(32'h20);
        chk("halt_pre", 64'(halted), 64'd0);
        cap(32'h20);
        chk("halt_flag",      64'(halted),    64'd1);
        chk("halt_cycle_cnt", 64'(cycle_cnt), 64'd5);
`ifdef TRACE_DEDUP_EN
        chk("halt_count", 64'(count), 64'd2);
`else
        chk("halt_count", 64'(count), 64'd5);
`endif
        cap(32'h30); cap(32'h34); cap(32'h38);
`ifdef TRACE_DEDUP_EN
        chk("done_count", 64'(count), 64'd2);
`else
        chk("done_count", 64'(count), 64'd5);
`endif
        chk("done_cycle_frozen", 64'(cycle_cnt),  64'd5);
        chk("done_core_reset",   64'(core_reset), 64'd0);
        chk("done_timeout",      64'(timeout),    64'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
`ifdef TRACE_DEDUP_EN
        chk("done_drain_count", 64'(count), 64'd1);
`else
        chk("done_drain_count", 64'(count), 64'd4);
`endif
        chk("done_drain_rd_pc", 64'(rd_pc), 64'h20);

        // Timeout after 100 RUN cycles with distinct PCs
        start();
        for (int i = 0; i < 99; i++) cap(32'(4 * i));
        chk("to_pre_flag",      64'(timeout),   64'd0);
        chk("to_pre_cycle_cnt", 64'(cycle_cnt), 64'd99);
        cap(32'(4 * 99));
        chk("to_flag",      64'(timeout),   64'd1);
        chk("to_cycle_cnt", 64'(cycle_cnt), 64'd100);
        chk("to_halted",    64'(halted),    64'd0);
        for (int i = 0; i < 5; i++) cap(32'h1000 + 32'(4 * i));
        chk("to_frozen_cycle_cnt", 64'(cycle_cnt), 64'd100);
        chk("to_count",            64'(count),     64'd16);
        chk("to_overflow",         64'(overflow),  64'd1);

        // Reset while DONE clears everything in one cycle
        reset = 1'b1;
        tick();
        chk("rr_flags",      64'({overflow, halted, timeout}), 64'd0);
        chk("rr_count",      64'(count),      64'd0);
        chk("rr_cycle_cnt",  64'(cycle_cnt),  64'd0);
        chk("rr_core_reset", 64'(core_reset), 64'd1);
        chk("rr_rd_valid",   64'(rd_valid),   64'd0);
        chk("rr_rd_pc",      64'(rd_pc),      64'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
